pt_check: RTL and testbench

Reader of the plaintext memory that the PRGA writes during ARC4 cracking.
- After a PRGA pass, the crack controller starts pt_check through the same en/rdy handshake the other ARC4 blocks use.
- pt_check scans the length-prefixed message: pt[0] is the length N, pt[1..N] are the characters.
- It reports whether every character is printable ASCII, which tells the controller whether the candidate key is plausible.
- It aborts at the first bad byte so the key search moves on quickly.

---
 rtl/arc4_pkg.sv | 22 ++
 rtl/pt_check.sv | 96 +++++++++
 tb/tb_pt_check.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 cracking definitions: plaintext checker states, printable ASCII
// bounds and the range test used by the checker.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LEN,
    WAIT_LEN,
    SCAN,
    FINISH
  } pt_check_state_t;

  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b,
                                        input logic [7:0] lo,
                                        input logic [7:0] hi);
    return (b >= lo) && (b <= hi);
  endfunction

endpackage

// File: rtl/pt_check.sv
// Scans the length-prefixed plaintext left by the PRGA and reports whether
// every character is printable, stopping at the first bad byte.
module pt_check
  import arc4_pkg::*;
#(
  parameter logic [7:0] PRINT_LO = ASCII_PRINT_LO,
  parameter logic [7:0] PRINT_HI = ASCII_PRINT_HI
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       done,
  output logic       valid,
  output logic [7:0] fail_idx
);

  pt_check_state_t state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [7:0]      fail_idx_q, fail_idx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= 8'd0;
      addr_q     <= 8'd0;
      valid_q    <= 1'b0;
      fail_idx_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // addr_q is the address presented last cycle, i.e. the index whose byte is
  // on pt_rddata now while scanning.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    fail_idx_d = fail_idx_q;
    case (state_q)
      IDLE, FINISH: begin
        if (en) begin
          state_d    = RD_LEN;
          valid_d    = 1'b0;
          fail_idx_d = 8'd0;
        end
      end
      RD_LEN: begin
        addr_d  = 8'd0;
        state_d = WAIT_LEN;
      end
      WAIT_LEN: begin
        len_d = pt_rddata;
        if (pt_rddata == 8'd0) begin
          valid_d = 1'b1;
          state_d = FINISH;
        end else begin
          addr_d  = 8'd1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!is_printable(pt_rddata, PRINT_LO, PRINT_HI)) begin
          fail_idx_d = addr_q;
          valid_d    = 1'b0;
          state_d    = FINISH;
        end else if (addr_q == len_q) begin
          valid_d = 1'b1;
          state_d = FINISH;
        end else begin
          addr_d = addr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The address is driven from next-state so memory data lines up one cycle
  // later with the index held in addr_q.
  assign pt_addr  = addr_d;
  assign rdy      = (state_q == IDLE) || (state_q == FINISH);
  assign done     = (state_q == FINISH);
  assign valid    = valid_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_pt_check.sv
// Randomised and directed bench for pt_check against a printable-ASCII model.
module tb_pt_check;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] pt_addr;
  logic [7:0] pt_rddata;
  logic       done;
  logic       valid;
  logic [7:0] fail_idx;

  logic [7:0] mem [256];

  int checks = 0;
  int fails  = 0;

  // observations from the most recent scan
  int         obs_lat;
  bit         obs_timeout;
  logic       obs_rdy1, obs_done1, obs_valid1;
  logic [7:0] obs_fail1;
  logic [7:0] obs_last_addr, obs_max_addr;
  logic [7:0] addr_seq [$];

  always #5 clk = ~clk;

  always @(posedge clk) pt_rddata <= mem[pt_addr];

  pt_check dut (
    .clk(clk), .rst(rst), .en(en), .rdy(rdy), .pt_addr(pt_addr),
    .pt_rddata(pt_rddata), .done(done), .valid(valid), .fail_idx(fail_idx)
  );

  // Message loader: msg[0] is the length, garbage fills the rest of memory.
  task automatic load(input logic [7:0] msg [$]);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < msg.size(); i++) mem[i] = msg[i];
  endtask

  // Reference: first index in 1..N outside [0x20,0x7E]; latency in edges
  // after the accepting edge until done is visible.
  task automatic model(output bit v, output logic [7:0] f, output int lat);
    int n;
    n = int'(mem[0]);
    v = 1'b1;
    f = 8'd0;
    lat = 2 + n;
    for (int k = 1; k <= n; k++) begin
      if (mem[k] < 8'h20 || mem[k] > 8'h7E) begin
        v = 1'b0;
        f = 8'(k);
        lat = 2 + k;
        break;
      end
    end
  endtask

  task automatic run_scan(input bit noise);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    obs_rdy1 = rdy; obs_done1 = done; obs_valid1 = valid; obs_fail1 = fail_idx;
    obs_lat = 0;
    obs_timeout = 1'b0;
    obs_max_addr = 8'd0;
    addr_seq.delete();
    while (!done && obs_lat < 400) begin
      if (addr_seq.size() == 0 || addr_seq[$] != pt_addr) addr_seq.push_back(pt_addr);
      if (pt_addr > obs_max_addr) obs_max_addr = pt_addr;
      @(negedge clk);
      if (noise && !rdy) en = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      en = 1'b0;
      obs_lat++;
    end
    if (!done) obs_timeout = 1'b1;
    obs_last_addr = pt_addr;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    checks++;
    if ({rdy, done, valid, fail_idx, pt_addr} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state rdy/done/valid/fail/addr got %b/%b/%b/%0d/%0d exp 1/0/0/0/0",
               rdy, done, valid, fail_idx, pt_addr);
    end
    $display("reset: rdy=%b done=%b", rdy, done);
  endtask

  task automatic test_happy;
    logic [7:0] m [$];
    m = '{8'd3, "H", "i", "!"};
    load(m);
    run_scan(1'b0);
    checks++;
    if (obs_timeout || obs_lat != 5 || valid !== 1'b1 || fail_idx !== 8'd0) begin
      fails++;
      $display("FAIL happy lat/valid/fail got %0d/%b/%0d exp 5/1/0", obs_lat, valid, fail_idx);
    end
    checks++;
    if (addr_seq.size() != 4 || addr_seq[0] != 0 || addr_seq[1] != 1 ||
        addr_seq[2] != 2 || addr_seq[3] != 3) begin
      fails++;
      $display("FAIL happy_addr_seq got %p exp 0,1,2,3", addr_seq);
    end
    checks++;
    if (obs_rdy1 !== 1'b0 || obs_done1 !== 1'b0) begin
      fails++;
      $display("FAIL happy_busy rdy/done at T+1 got %b/%b exp 0/0", obs_rdy1, obs_done1);
    end
    $display("happy: lat=%0d valid=%b fail_idx=%0d", obs_lat, valid, fail_idx);
  endtask

  task automatic test_empty;
    logic [7:0] m [$];
    m = '{8'd0};
    load(m);
    run_scan(1'b0);
    checks++;
    if (obs_timeout || obs_lat != 2 || valid !== 1'b1 || fail_idx !== 8'd0 || obs_max_addr != 0) begin
      fails++;
      $display("FAIL empty lat/valid/fail/maxaddr got %0d/%b/%0d/%0d exp 2/1/0/0",
               obs_lat, valid, fail_idx, obs_max_addr);
    end
    $display("empty: lat=%0d valid=%b", obs_lat, valid);
  endtask

  task automatic test_abort;
    logic [7:0] m [$];
    m = '{8'd5, 8'h41, 8'h7F, 8'h41, 8'h41, 8'h41};
    load(m);
    run_scan(1'b0);
    checks++;
    if (obs_timeout || obs_lat != 4 || valid !== 1'b0 || fail_idx !== 8'd2) begin
      fails++;
      $display("FAIL abort lat/valid/fail got %0d/%b/%0d exp 4/0/2", obs_lat, valid, fail_idx);
    end
    $display("abort: lat=%0d valid=%b fail_idx=%0d", obs_lat, valid, fail_idx);
  endtask

  task automatic test_bounds;
    logic [7:0] m [$];
    bit ev; logic [7:0] ef; int el;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: m = '{8'd3, 8'h20, 8'h7E, 8'h41};
        1: m = '{8'd1, 8'h1F};
        2: m = '{8'd1, 8'h80};
        default: m = '{8'd2, 8'h41, 8'h7F};
      endcase
      load(m);
      model(ev, ef, el);
      run_scan(1'b0);
      checks++;
      if (obs_timeout || obs_lat != el || valid !== ev || fail_idx !== ef) begin
        fails++;
        $display("FAIL bounds%0d lat/valid/fail got %0d/%b/%0d exp %0d/%b/%0d",
                 t, obs_lat, valid, fail_idx, el, ev, ef);
      end
      $display("bounds%0d: lat=%0d valid=%b fail_idx=%0d", t, obs_lat, valid, fail_idx);
    end
  endtask

  task automatic test_len255;
    for (int i = 0; i < 256; i++) mem[i] = 8'h41;
    mem[0] = 8'd255;
    run_scan(1'b0);
    checks++;
    if (obs_timeout || obs_lat != 257 || valid !== 1'b1 || obs_last_addr != 255 || obs_max_addr != 255) begin
      fails++;
      $display("FAIL len255 lat/valid/last/max got %0d/%b/%0d/%0d exp 257/1/255/255",
               obs_lat, valid, obs_last_addr, obs_max_addr);
    end
    $display("len255: lat=%0d valid=%b last_addr=%0d", obs_lat, valid, obs_last_addr);
  endtask

  task automatic test_random(input bit noise);
    bit ev; logic [7:0] ef; int el; int n;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      n = $urandom_range(0, 24);
      mem[0] = 8'(n);
      for (int k = 1; k <= n; k++) begin
        mem[k] = 8'($urandom_range(32, 126));
        if ($urandom_range(0, 29) == 0) mem[k] = 8'($urandom_range(127, 255));
        if ($urandom_range(0, 29) == 0) mem[k] = 8'($urandom_range(0, 31));
      end
      model(ev, ef, el);
      run_scan(noise);
      checks++;
      if (obs_timeout || obs_lat != el || valid !== ev || fail_idx !== ef || obs_max_addr > 8'(n)) begin
        fails++;
        $display("FAIL random%0d n=%0d noise=%b lat/valid/fail/max got %0d/%b/%0d/%0d exp %0d/%b/%0d/<=%0d",
                 t, n, noise, obs_lat, valid, fail_idx, obs_max_addr, el, ev, ef, n);
      end
      $display("random%0d noise=%b n=%0d: lat=%0d valid=%b fail_idx=%0d",
               t, noise, n, obs_lat, valid, fail_idx);
    end
  endtask

  task automatic test_mid_reset;
    bit idle_ok;
    for (int i = 1; i < 256; i++) mem[i] = 8'h41;
    mem[0] = 8'd200;
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1; en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++;
    if ({rdy, done, valid, fail_idx, pt_addr} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
      fails++;
      $display("FAIL mid_reset rdy/done/valid/fail/addr got %b/%b/%b/%0d/%0d exp 1/0/0/0/0",
               rdy, done, valid, fail_idx, pt_addr);
    end
    idle_ok = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || rdy !== 1'b1) idle_ok = 1'b0;
    end
    checks++;
    if (!idle_ok) begin
      fails++;
      $display("FAIL mid_reset_idle done/rdy got %b/%b exp 0/1", done, rdy);
    end
    $display("mid_reset: rdy=%b done=%b", rdy, done);
  endtask

  task automatic test_back_to_back;
    logic [7:0] m [$];
    m = '{8'd2, 8'h41, 8'h7F};
    load(m);
    run_scan(1'b0);
    m = '{8'd2, 8'h41, 8'h42};
    load(m);
    run_scan(1'b0);
    checks++;
    if (obs_done1 !== 1'b0 || obs_valid1 !== 1'b0 || obs_fail1 !== 8'd0 || obs_rdy1 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_clear done/valid/fail/rdy at T+1 got %b/%b/%0d/%b exp 0/0/0/0",
               obs_done1, obs_valid1, obs_fail1, obs_rdy1);
    end
    checks++;
    if (obs_timeout || obs_lat != 4 || valid !== 1'b1 || fail_idx !== 8'd0) begin
      fails++;
      $display("FAIL b2b_result lat/valid/fail got %0d/%b/%0d exp 4/1/0", obs_lat, valid, fail_idx);
    end
    $display("back_to_back: lat=%0d valid=%b", obs_lat, valid);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_happy();
    test_empty();
    test_abort();
    test_bounds();
    test_len255();
    test_random(1'b0);
    test_random(1'b1);
    test_mid_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
